// File: rtl/fpu_adds_unit.sv
// fpu_adds_unit: multi-cycle Float32 adder (CMP/ALN/ADD/NRM), flush-to-zero.
// Define FPU_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fpu_adds_unit #(
  parameter int DST_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      fs,
  input  logic [31:0]      ft,
  input  logic [DST_W-1:0] fd_addr,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic [DST_W-1:0] dst
);

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    ALN,
    ADD,
    NRM
  } state_t;

  state_t state, state_nx;

  logic [31:0]      op_a, op_b;
  logic [DST_W-1:0] op_dst;
  logic [31:0]      gt_r;
  logic             lt_sgn;
  logic [22:0]      lt_mnt;
  logic [7:0]       e_dif;
  logic             spc;
  logic [31:0]      spc_res;
  logic [26:0]      ma_r, mb_r;
  logic [27:0]      sum_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CMP;
      CMP:     state_nx = ALN;
      ALN:     state_nx = ADD;
      ADD:     state_nx = NRM;
      NRM:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // compare stage
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        a_zero, b_zero, a_big;
  logic        spc_nx;
  logic [31:0] spc_res_nx;
  logic [7:0]  e_dif_nx;

  assign a_nan  = (&op_a[30:23]) & (|op_a[22:0]);
  assign b_nan  = (&op_b[30:23]) & (|op_b[22:0]);
  assign a_inf  = (&op_a[30:23]) & ~(|op_a[22:0]);
  assign b_inf  = (&op_b[30:23]) & ~(|op_b[22:0]);
  assign a_zero = ~(|op_a[30:23]);
  assign b_zero = ~(|op_b[30:23]);
  assign a_big  = (op_a[30:0] >= op_b[30:0]);

  always_comb begin
    spc_nx     = 1'b0;
    spc_res_nx = 32'h0;
    e_dif_nx   = a_big ? (op_a[30:23] - op_b[30:23])
                       : (op_b[30:23] - op_a[30:23]);
    if (a_nan | b_nan | (a_inf & b_inf & (op_a[31] ^ op_b[31]))) begin
      spc_nx     = 1'b1;
      spc_res_nx = 32'h7FC0_0000;
    end else if (a_inf) begin
      spc_nx     = 1'b1;
      spc_res_nx = op_a;
    end else if (b_inf) begin
      spc_nx     = 1'b1;
      spc_res_nx = op_b;
    end else if (a_zero) begin
      spc_nx     = 1'b1;
      spc_res_nx = op_b;
    end else if (b_zero) begin
      spc_nx     = 1'b1;
      spc_res_nx = op_a;
    end
  end

  // align stage: 24-bit mantissa plus guard, round, sticky
  logic [49:0] lt_ext, lt_sh;
  logic [26:0] ma_nx, mb_nx;

  assign lt_ext = {1'b1, lt_mnt, 26'h0};
  assign lt_sh  = lt_ext >> e_dif;
  assign ma_nx  = {1'b1, gt_r[22:0], 3'b000};

  always_comb begin
    mb_nx = {lt_sh[49:24], |lt_sh[23:0]};
    if (e_dif >= 8'd27) mb_nx = 27'd1;
  end

  // add stage
  logic [27:0] sum_nx;

  always_comb begin
    if (gt_r[31] ^ lt_sgn) sum_nx = {1'b0, ma_r} - {1'b0, mb_r};
    else                   sum_nx = {1'b0, ma_r} + {1'b0, mb_r};
  end

  // normalize and round stage
  logic [4:0]        lz;
  logic [26:0]       m_n;
  logic signed [9:0] e_n, e_r;
  logic [22:0]       mant;
  logic [31:0]       res_nx;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum_r[i]) lz = 5'(26 - i);
    end
  end

  always_comb begin
    if (sum_r[27]) begin
      m_n = {sum_r[27:2], sum_r[1] | sum_r[0]};
      e_n = $signed({2'b00, gt_r[30:23]}) + 10'sd1;
    end else begin
      m_n = sum_r[26:0] << lz;
      e_n = $signed({2'b00, gt_r[30:23]}) - $signed({5'b00000, lz});
    end
  end

`ifdef FPU_RNE_EN
  logic        rnd_inc;
  logic [24:0] m_r;

  assign rnd_inc = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
  assign m_r     = {1'b0, m_n[26:3]} + {24'h0, rnd_inc};

  always_comb begin
    if (m_r[24]) begin
      mant = m_r[23:1];
      e_r  = e_n + 10'sd1;
    end else begin
      mant = m_r[22:0];
      e_r  = e_n;
    end
  end
`else
  logic unused_rnd;

  assign unused_rnd = ^{m_n[26], m_n[2:0]};
  assign mant       = m_n[25:3];
  assign e_r        = e_n;
`endif

  always_comb begin
    res_nx = {gt_r[31], e_r[7:0], mant};
    if (spc)                   res_nx = spc_res;
    else if (sum_r == 28'h0)   res_nx = 32'h0;
    else if (e_r <= 10'sd0)    res_nx = {gt_r[31], 31'h0};
    else if (e_r >= 10'sd255)  res_nx = {gt_r[31], 8'hFF, 23'h0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      op_dst  <= '0;
      gt_r    <= '0;
      lt_sgn  <= 1'b0;
      lt_mnt  <= '0;
      e_dif   <= '0;
      spc     <= 1'b0;
      spc_res <= '0;
      ma_r    <= '0;
      mb_r    <= '0;
      sum_r   <= '0;
      result  <= '0;
      dst     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= fs;
            op_b   <= ft;
            op_dst <= fd_addr;
          end
        end
        CMP: begin
          gt_r    <= a_big ? op_a : op_b;
          lt_sgn  <= a_big ? op_b[31] : op_a[31];
          lt_mnt  <= a_big ? op_b[22:0] : op_a[22:0];
          e_dif   <= e_dif_nx;
          spc     <= spc_nx;
          spc_res <= spc_res_nx;
        end
        ALN: begin
          ma_r <= ma_nx;
          mb_r <= mb_nx;
        end
        ADD: sum_r <= sum_nx;
        NRM: begin
          result <= res_nx;
          dst    <= op_dst;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
